result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/systolic_pkg.sv | 16 +
 rtl/edge_detect.sv | 22 ++
 rtl/result_collector.sv | 172 +++++++++++++++++
 tb/tb_result_collector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array and its result collector.
package systolic_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned N                  = 4;
  localparam int unsigned NUM_RESULTS        = N * N;
  localparam int unsigned IDX_W              = 5;
  localparam int unsigned ADDR_W             = $clog2(NUM_RESULTS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } collector_state_e;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: rise_c is high while din=1 and the previous sample was 0.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
    rise_c = din & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

endmodule

// File: rtl/result_collector.sv
// Captures the 16 systolic-array accumulators on an array_done rising edge and streams them
// out over a valid/ready port. COLLECTOR_CHECKSUM_EN appends a modulo-2^W sum as beat 16.
module result_collector
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  array_done,
  input  logic [DATA_WIDTH-1:0] result0,
  input  logic [DATA_WIDTH-1:0] result1,
  input  logic [DATA_WIDTH-1:0] result2,
  input  logic [DATA_WIDTH-1:0] result3,
  input  logic [DATA_WIDTH-1:0] result4,
  input  logic [DATA_WIDTH-1:0] result5,
  input  logic [DATA_WIDTH-1:0] result6,
  input  logic [DATA_WIDTH-1:0] result7,
  input  logic [DATA_WIDTH-1:0] result8,
  input  logic [DATA_WIDTH-1:0] result9,
  input  logic [DATA_WIDTH-1:0] result10,
  input  logic [DATA_WIDTH-1:0] result11,
  input  logic [DATA_WIDTH-1:0] result12,
  input  logic [DATA_WIDTH-1:0] result13,
  input  logic [DATA_WIDTH-1:0] result14,
  input  logic [DATA_WIDTH-1:0] result15,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  missed
);

`ifdef COLLECTOR_CHECKSUM_EN
  localparam int unsigned LAST_IDX = NUM_RESULTS;
`else
  localparam int unsigned LAST_IDX = NUM_RESULTS - 1;
`endif

  collector_state_e state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  missed_q, missed_d;
`ifdef COLLECTOR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  logic [DATA_WIDTH-1:0] res_c [NUM_RESULTS];
  logic [DATA_WIDTH-1:0] buf_q [NUM_RESULTS];
  logic                  buf_we_c;
  logic                  rise_c;
  logic [IDX_W-1:0]      nxt_idx_c;

  edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .din    (array_done),
    .rise_c (rise_c)
  );

  always_comb begin
    res_c[0]  = result0;  res_c[1]  = result1;  res_c[2]  = result2;  res_c[3]  = result3;
    res_c[4]  = result4;  res_c[5]  = result5;  res_c[6]  = result6;  res_c[7]  = result7;
    res_c[8]  = result8;  res_c[9]  = result9;  res_c[10] = result10; res_c[11] = result11;
    res_c[12] = result12; res_c[13] = result13; res_c[14] = result14; res_c[15] = result15;
  end

  // Next-state and registered-output logic; out_data is preloaded with the next beat on accept.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    missed_d     = missed_q | (rise_c & (state_q != ST_IDLE));
    buf_we_c     = 1'b0;
    nxt_idx_c    = idx_q + IDX_W'(1);
`ifdef COLLECTOR_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rise_c) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        buf_we_c = 1'b1;
        state_d  = ST_DRAIN;
        idx_d    = '0;
        data_d   = res_c[0];
        valid_d  = 1'b1;
        last_d   = 1'b0;
`ifdef COLLECTOR_CHECKSUM_EN
        sum_d    = '0;
`endif
      end
      ST_DRAIN: begin
        if (valid_q && out_ready) begin
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d      = ST_IDLE;
            valid_d      = 1'b0;
            idx_d        = '0;
            data_d       = '0;
            last_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            idx_d  = nxt_idx_c;
            last_d = (nxt_idx_c == IDX_W'(LAST_IDX));
`ifdef COLLECTOR_CHECKSUM_EN
            sum_d  = sum_q + data_q;
            if (nxt_idx_c == IDX_W'(NUM_RESULTS)) data_d = sum_q + data_q;
            else                                  data_d = buf_q[nxt_idx_c[ADDR_W-1:0]];
`else
            data_d = buf_q[nxt_idx_c[ADDR_W-1:0]];
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      missed_q     <= 1'b0;
`ifdef COLLECTOR_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      missed_q     <= missed_d;
`ifdef COLLECTOR_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  // Result buffer has no reset; it is only meaningful after a CAPTURE.
  always_ff @(posedge clk) begin
    if (buf_we_c) buf_q <= res_c;
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_index  = idx_q;
  assign out_last   = last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: stimulus pushes expected beats, a negedge monitor checks them.
module tb_result_collector;

  localparam int DW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [4:0]    idx;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          array_done = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] res [16];
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [4:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          frame_done;
  logic          missed;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rmode = 0;
  int tbase = 0;
  int raise_cyc = 0;
  int lat_pend = 0;
  int fd_count = 0;
  int beats_acc = 0;
  int in_frame = 0;
  int first_cyc = 0;
  int last_span = 0;
  beat_t sb[$];

  result_collector #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .array_done(array_done),
    .result0(res[0]),   .result1(res[1]),   .result2(res[2]),   .result3(res[3]),
    .result4(res[4]),   .result5(res[5]),   .result6(res[6]),   .result7(res[7]),
    .result8(res[8]),   .result9(res[9]),   .result10(res[10]), .result11(res[11]),
    .result12(res[12]), .result13(res[13]), .result14(res[14]), .result15(res[15]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .busy(busy),
    .frame_done(frame_done), .missed(missed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready: 0 = always, 1 = alternating starting on the first valid cycle, else random.
  always @(posedge clk) begin
    #1;
    if (rmode == 0)      out_ready = 1'b1;
    else if (rmode == 1) out_ready = ((cyc - tbase) % 2 == 0);
    else                 out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares accepted beats, stall stability, bubbles, latency and frame_done timing.
  logic [DW-1:0] h_data;
  logic [4:0]    h_idx;
  logic          h_last;
  int            h_v = 0;
  int            exp_fd = 0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      sb.delete();
      in_frame = 0;
      h_v = 0;
      exp_fd = 0;
      lat_pend = 0;
    end else begin
      if (frame_done || exp_fd != 0) check("frame_done", 64'(frame_done), 64'(exp_fd != 0));
      if (frame_done) fd_count++;
      exp_fd = 0;
      if (h_v != 0) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, h_data);
        check("stall_index", 64'(out_index), 64'(h_idx));
        check("stall_last", 64'(out_last), 64'(h_last));
      end
      if (in_frame != 0) check("no_bubble", 64'(out_valid), 64'd1);
      h_v = 0;
      if (out_valid) begin
        if (in_frame == 0) begin
          in_frame = 1;
          first_cyc = cyc;
          if (lat_pend != 0) begin
            check("first_valid_latency", 64'(cyc - raise_cyc), 64'd2);
            lat_pend = 0;
          end
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_index", 64'(out_index), 64'(e.idx));
            check("beat_last", 64'(out_last), 64'(e.last));
            beats_acc++;
            if (e.last) begin
              in_frame = 0;
              last_span = cyc - first_cyc + 1;
              exp_fd = 1;
            end
          end
        end else begin
          h_v = 1;
          h_data = out_data;
          h_idx = out_index;
          h_last = out_last;
        end
      end
    end
  end

  // Reference model: the frame is the 16 words as presented, optionally followed by their sum.
  task automatic push_expected();
    logic [DW-1:0] sum = '0;
    logic          cks = 1'b0;
`ifdef COLLECTOR_CHECKSUM_EN
    cks = 1'b1;
`endif
    for (int i = 0; i < 16; i++) begin
      sb.push_back('{data: res[i], idx: 5'(i), last: (i == 15) && !cks});
      sum = sum + res[i];
    end
    if (cks) sb.push_back('{data: sum, idx: 5'd16, last: 1'b1});
  endtask

  task automatic load_matmul();
    int a [4][4];
    int b [4][4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = 4 * r + 3 - c;
        b[r][c] = 12 + r - 4 * c;
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int acc = 0;
        for (int k = 0; k < 4; k++) acc += a[r][k] * b[k][c];
        res[4 * r + c] = DW'(acc);
      end
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) res[i] = {$urandom, $urandom};
  endtask

  task automatic issue_frame(input int hold);
    push_expected();
    @(posedge clk); #1;
    array_done = 1'b1;
    raise_cyc = cyc;
    tbase = cyc + 2;
    lat_pend = 1;
    repeat (hold) @(posedge clk);
    #1 array_done = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (fd_count < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("frame_count", 64'(fd_count), 64'(target));
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_index", 64'(out_index), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_missed", 64'(missed), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < 16; i++) res[i] = '0;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reference product, full-rate drain.
    rmode = 0;
    load_matmul();
    issue_frame(3);
    wait_frames(1);
    check("span_full_rate", 64'(last_span), 64'd16);
    check("missed_after_a", 64'(missed), 64'd0);
    check("busy_after_a", 64'(busy), 64'd0);

    // Same data, alternating ready.
    rmode = 1;
    issue_frame(1);
    wait_frames(2);
    check("span_toggle", 64'(last_span), 64'd31);

    // array_done held high for 50 cycles yields exactly one frame.
    rmode = 0;
    issue_frame(50);
    repeat (10) @(posedge clk);
    wait_frames(3);
    check("held_high_queue_empty", 64'(sb.size()), 64'd0);
    check("held_high_missed", 64'(missed), 64'd0);

    // Second pulse during DRAIN with changed inputs: buffer must stay intact.
    rmode = 2;
    load_matmul();
    issue_frame(2);
    n = 0;
    while (in_frame == 0 && n < 50) begin @(posedge clk); n++; end
    check("drain_reached", 64'(in_frame), 64'd1);
    @(posedge clk); #1;
    array_done = 1'b1;
    load_random();
    @(posedge clk); #1 array_done = 1'b0;
    wait_frames(4);
    check("missed_set", 64'(missed), 64'd1);
    check("busy_after_d", 64'(busy), 64'd0);

    // Reset after beat 5 is accepted aborts the frame.
    rmode = 0;
    load_random();
    base = beats_acc;
    issue_frame(2);
    n = 0;
    while (beats_acc < base + 6 && n < 100) begin @(posedge clk); n++; end
    check("beats_before_reset", 64'(beats_acc - base), 64'd6);
    @(posedge clk); #1 rst = 1'b1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("no_frame_done_after_reset", 64'(fd_count), 64'd4);
    check("idle_after_reset", 64'(out_valid), 64'd0);

    // Fresh frames after reset, random data and random backpressure.
    rmode = 2;
    for (int f = 0; f < 3; f++) begin
      load_random();
      issue_frame(1 + f);
      wait_frames(5 + f);
    end
    check("missed_clean", 64'(missed), 64'd0);
    check("final_queue_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
